mcpu_control: RTL and testbench

MCPU_CONTROL -- requirements
Module: mcpu_control

---
 rtl/mcpu_defs.sv | 48 ++++
 rtl/step_edge.sv | 12 +
 rtl/mcpu_control.sv | 125 ++++++++++++
 tb/tb_mcpu_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mcpu_defs.sv
// mcpu_defs: shared state, opcode/funct and control-code definitions for the multicycle CPU controller
package mcpu_defs;
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5} state_t;
  typedef enum logic [2:0] {C_ALU_R, C_ALU_I, C_MEM, C_BR, C_J, C_JR, C_BAD} cls_t;
  typedef struct packed {cls_t cls; logic [2:0] alu; logic link;} dec_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SRL = 6'h02, F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000, ALU_OR = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b011, ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SLT = 3'b111;
  localparam logic [1:0] PC_ALU = 2'b00, PC_OUT = 2'b01, PC_JMP = 2'b10, PC_RS = 2'b11;
  localparam logic [1:0] D_ALU = 2'b00, D_MDR = 2'b01, D_LUI = 2'b10, D_PC = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] SB_RT = 2'b00, SB_4 = 2'b01, SB_IMM = 2'b10, SB_BR = 2'b11;
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fun);
    dec_t d;
    d = '{C_BAD, ALU_ADD, 1'b0};
    case (op)
      OP_R:
        case (fun)
          F_ADD:   d = '{C_ALU_R, ALU_ADD, 1'b0};
          F_SUB:   d = '{C_ALU_R, ALU_SUB, 1'b0};
          F_AND:   d = '{C_ALU_R, ALU_AND, 1'b0};
          F_OR:    d = '{C_ALU_R, ALU_OR, 1'b0};
          F_XOR:   d = '{C_ALU_R, ALU_XOR, 1'b0};
          F_NOR:   d = '{C_ALU_R, ALU_NOR, 1'b0};
          F_SLT:   d = '{C_ALU_R, ALU_SLT, 1'b0};
          F_SRL:   d = '{C_ALU_R, ALU_SRL, 1'b0};
          F_JR:    d = '{C_JR, ALU_ADD, 1'b0};
          F_JALR:  d = '{C_JR, ALU_ADD, 1'b1};
          default: d = '{C_BAD, ALU_ADD, 1'b0};
        endcase
      OP_ADDI, OP_LUI: d = '{C_ALU_I, ALU_ADD, 1'b0};
      OP_ANDI: d = '{C_ALU_I, ALU_AND, 1'b0};
      OP_ORI:  d = '{C_ALU_I, ALU_OR, 1'b0};
      OP_XORI: d = '{C_ALU_I, ALU_XOR, 1'b0};
      OP_SLTI: d = '{C_ALU_I, ALU_SLT, 1'b0};
      OP_LW, OP_SW: d = '{C_MEM, ALU_ADD, 1'b0};
      OP_BEQ, OP_BNE: d = '{C_BR, ALU_SUB, 1'b0};
      OP_J:    d = '{C_J, ALU_ADD, 1'b0};
      OP_JAL:  d = '{C_J, ALU_ADD, 1'b1};
      default: d = '{C_BAD, ALU_ADD, 1'b0};
    endcase
    return d;
  endfunction
endpackage

// File: rtl/step_edge.sv
// step_edge: rising-edge detector for the debug step request
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk)
    prev <= rst_n ? d : 1'b0;
  assign rise = d & ~prev;
endmodule

// File: rtl/mcpu_control.sv
// mcpu_control: multicycle CPU control FSM with retire counter, memory timeout and debug halt/step
module mcpu_control
  import mcpu_defs::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fun,
  input  logic             zero,
  input  logic             mem_ack,
  input  logic             debug_en,
  input  logic             debug_step,
  output logic             mem_req,
  output logic             mem_w,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       DatatoReg,
  output logic             ALUSrc_A,
  output logic [1:0]       ALUSrc_B,
  output logic [2:0]       ALU_Control,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t cs, nxt;
  logic [5:0] op_q, fun_q;
  logic [WW-1:0] wait_cnt;
  logic step_rise, retire, tmo, last_wait;
  dec_t d;
  step_edge u_step (.clk(clk), .rst_n(rst_n), .d(debug_step), .rise(step_rise));
  assign state = cs;
  assign halted = cs == S_HALT;
  assign d = decode(op_q, fun_q);
  assign last_wait = !mem_ack && wait_cnt == WW'(TIMEOUT - 1);
  assign RegDst = (d.cls == C_ALU_R || d.cls == C_JR) ? RD_RD : d.cls == C_J ? RD_RA : RD_RT;
  assign DatatoReg = d.link ? D_PC : op_q == OP_LW ? D_MDR : op_q == OP_LUI ? D_LUI : D_ALU;
  always_comb begin
    nxt = cs;
    {mem_req, mem_w, IorD, IRWrite, PCWrite, RegWrite, illegal, ALUSrc_A, retire, tmo} = '0;
    PCSource = PC_ALU;
    ALUSrc_B = SB_RT;
    ALU_Control = ALU_ADD;
    case (cs)
      S_IF: begin
        mem_req = 1'b1;
        ALUSrc_B = SB_4;
        {IRWrite, PCWrite} = {2{mem_ack}};
        tmo = last_wait;
        nxt = mem_ack ? S_ID : last_wait ? S_HALT : S_IF;
      end
      S_ID: begin
        ALUSrc_B = SB_BR;
        nxt = S_EX;
      end
      S_EX: begin
        ALU_Control = d.alu;
        ALUSrc_A = !(d.cls == C_ALU_R && d.alu == ALU_SRL);
        ALUSrc_B = (d.cls == C_ALU_I || d.cls == C_MEM) ? SB_IMM : SB_RT;
        case (d.cls)
          C_ALU_R, C_ALU_I: nxt = S_WB;
          C_MEM: nxt = S_MEM;
          C_BR: begin
            PCWrite = zero ^ (op_q == OP_BNE);
            PCSource = PC_OUT;
            retire = 1'b1;
          end
          C_J, C_JR: begin
            PCWrite = 1'b1;
            PCSource = d.cls == C_J ? PC_JMP : PC_RS;
            RegWrite = d.link;
            retire = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        IorD = 1'b1;
        mem_w = op_q == OP_SW;
        ALUSrc_A = 1'b1;
        ALUSrc_B = SB_IMM;
        retire = mem_ack && op_q != OP_LW;
        tmo = last_wait;
        nxt = mem_ack ? S_WB : last_wait ? S_HALT : S_MEM;
      end
      S_WB: begin
        RegWrite = 1'b1;
        retire = 1'b1;
      end
      S_HALT: nxt = (!bus_err && (!debug_en || step_rise)) ? S_IF : S_HALT;
      default: nxt = S_IF;
    endcase
    if (retire) nxt = debug_en ? S_HALT : S_IF;
    if (!rst_n) {mem_req, mem_w, IRWrite, PCWrite, RegWrite, illegal} = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs <= S_IF;
      op_q <= '0;
      fun_q <= '0;
      wait_cnt <= '0;
      instr_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      cs <= nxt;
      if (cs == S_ID) {op_q, fun_q} <= {opcode, fun};
      wait_cnt <= ((cs == S_IF || cs == S_MEM) && !mem_ack) ? wait_cnt + 1'b1 : '0;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
      if (tmo) bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mcpu_control.sv
// tb_mcpu_control: directed self-checking bench for mcpu_control (CNT_W=4 to exercise counter wrap)
module tb_mcpu_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ack = 1'b0, debug_en = 1'b0, debug_step = 1'b0;
  logic [5:0] opcode = '0, fun = '0;
  logic mem_req, mem_w, IorD, IRWrite, PCWrite, RegWrite, ALUSrc_A, illegal, bus_err, halted;
  logic [1:0] PCSource, RegDst, DatatoReg, ALUSrc_B;
  logic [2:0] ALU_Control, state;
  logic [3:0] instr_cnt;
  logic [3:0] exp_cnt = '0;
  int checks = 0, errors = 0;
  mcpu_control #(.CNT_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fun(fun), .zero(zero), .mem_ack(mem_ack),
    .debug_en(debug_en), .debug_step(debug_step), .mem_req(mem_req), .mem_w(mem_w), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst),
    .DatatoReg(DatatoReg), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control),
    .state(state), .instr_cnt(instr_cnt), .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic retired;
    exp_cnt = exp_cnt + 4'd1;
    chk("retire_state", state, 0);
    chk("instr_cnt", instr_cnt, exp_cnt);
  endtask
  // Leaves the DUT in EX with opcode/fun scrambled, so EX must use the latched copy.
  task automatic fetch(input logic [5:0] op, input logic [5:0] f);
    opcode = op;
    fun = f;
    mem_ack = 1'b1;
    #1;
    chk("if_state", state, 0);
    chk("if_strobes", {mem_req, IorD, IRWrite, PCWrite, PCSource}, 6'b101100);
    chk("if_alu", {ALUSrc_A, ALUSrc_B, ALU_Control}, 6'b001010);
    tick;
    mem_ack = 1'b0;
    #1;
    chk("id_state", state, 1);
    chk("id_srcb", ALUSrc_B, 2'b11);
    tick;
    opcode = 6'h3F;
    fun = 6'h3F;
    #1;
    chk("ex_state", state, 2);
  endtask
  initial begin
    tick;
    tick;
    mem_ack = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_flags", {bus_err, halted, illegal}, 0);
    chk("rst_strobes", {mem_req, mem_w, IRWrite, PCWrite, RegWrite}, 0);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    fetch(6'h00, 6'h20);
    chk("add_ex", {ALUSrc_A, ALUSrc_B, ALU_Control}, 6'b100010);
    chk("add_ex_nowr", RegWrite, 0);
    tick;
    chk("add_wb", {state, RegWrite, RegDst}, {3'd4, 1'b1, 2'b01});
    tick;
    chk("add_done_rw", RegWrite, 0);
    retired;
    fetch(6'h23, 6'h00);
    chk("lw_ex", {ALUSrc_A, ALUSrc_B, ALU_Control}, 6'b110010);
    tick;
    chk("lw_mem", {state, mem_req, IorD, mem_w}, {3'd3, 3'b110});
    tick;
    tick;
    tick;
    chk("lw_mem_wait", {state, mem_req, IorD}, {3'd3, 2'b11});
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("lw_wb", {state, RegWrite, DatatoReg, RegDst}, {3'd4, 1'b1, 2'b01, 2'b00});
    tick;
    retired;
    fetch(6'h2B, 6'h00);
    tick;
    chk("sw_mem", {state, mem_req, IorD, mem_w}, {3'd3, 3'b111});
    mem_ack = 1'b1;
    #1;
    chk("sw_nowb", RegWrite, 0);
    tick;
    mem_ack = 1'b0;
    retired;
    fetch(6'h04, 6'h00);
    chk("beq_alu", {ALUSrc_A, ALUSrc_B, ALU_Control}, 6'b100110);
    chk("beq_z0", PCWrite, 0);
    zero = 1'b1;
    #1;
    chk("beq_z1", {PCWrite, PCSource}, 3'b101);
    tick;
    zero = 1'b0;
    retired;
    fetch(6'h05, 6'h00);
    chk("bne_z0", {PCWrite, PCSource}, 3'b101);
    zero = 1'b1;
    #1;
    chk("bne_z1", PCWrite, 0);
    tick;
    zero = 1'b0;
    retired;
    fetch(6'h03, 6'h00);
    chk("jal_ex", {PCWrite, PCSource, RegWrite, RegDst, DatatoReg}, {1'b1, 2'b10, 1'b1, 2'b10, 2'b11});
    tick;
    retired;
    fetch(6'h0F, 6'h00);
    chk("lui_ex", ALUSrc_B, 2'b10);
    tick;
    chk("lui_wb", {RegWrite, DatatoReg, RegDst}, 5'b11000);
    tick;
    retired;
    fetch(6'h3F, 6'h00);
    chk("ill_pulse", illegal, 1);
    chk("ill_nowr", {RegWrite, PCWrite, mem_req, mem_w, IRWrite}, 0);
    tick;
    chk("ill_clear", illegal, 0);
    retired;
    fetch(6'h00, 6'h02);
    chk("srl_ex", {ALUSrc_A, ALUSrc_B, ALU_Control}, 6'b000101);
    tick;
    tick;
    retired;
    debug_en = 1'b1;
    fetch(6'h00, 6'h20);
    tick;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    chk("dbg_halt", {state, halted}, {3'd5, 1'b1});
    chk("dbg_halt_strobes", {mem_req, RegWrite, PCWrite, IRWrite}, 0);
    chk("dbg_cnt", instr_cnt, exp_cnt);
    tick;
    chk("dbg_stay", state, 5);
    debug_step = 1'b1;
    tick;
    chk("dbg_step", {state, halted}, 4'b0000);
    fetch(6'h02, 6'h00);
    tick;
    exp_cnt = exp_cnt + 4'd1;
    chk("dbg_rehalt", state, 5);
    chk("dbg_cnt2", instr_cnt, exp_cnt);
    tick;
    tick;
    tick;
    chk("dbg_hold", {state, instr_cnt}, {3'd5, exp_cnt});
    debug_en = 1'b0;
    tick;
    chk("dbg_release", {state, halted}, 4'b0000);
    repeat (14) tick;
    chk("ack_wait14", {state, bus_err}, 4'b0000);
    fetch(6'h02, 6'h00);
    chk("ack_wins", {bus_err, halted}, 0);
    tick;
    retired;
    for (int i = 0; i < 4; i++) begin
      fetch(6'h02, 6'h00);
      tick;
      retired;
    end
    chk("cnt_wrap", instr_cnt, 0);
    repeat (14) tick;
    chk("tmo_pre", {state, bus_err, halted}, 5'b00000);
    tick;
    chk("tmo_err", {state, bus_err, halted}, {3'd5, 2'b11});
    chk("tmo_strobes", {mem_req, RegWrite, PCWrite, IRWrite}, 0);
    debug_step = 1'b0;
    tick;
    debug_step = 1'b1;
    tick;
    tick;
    chk("tmo_sticky", {state, bus_err}, {3'd5, 1'b1});
    rst_n = 1'b0;
    tick;
    chk("rst2", {state, bus_err, halted, instr_cnt}, 9'd0);
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
